keycode_event_decoder: RTL and testbench
========================================

# keycode_event_decoder

Sequential successor to the combinational keycode mapper for the Simon game. It consumes a stream of raw PS/2 scan-code bytes and tracks the break (F0) and extended (E0) prefixes. It maintains a held-key bitmap so that typematic repeats are suppressed, and queues decoded key events in a small FIFO. Events leave on a valid/ready interface to the game controller. It sits between the PS/2 receiver and the game FSM.

## Interface
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2
- NUM_KEYS, 5, number of mapped keys; fixed mapping below uses 5, higher values leave upper held bits permanently 0
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- scan_valid  in  1  one-cycle strobe, scan_byte valid
- scan_byte  in  8  received PS/2 byte
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_code  out  3  key at head: 0 q/green, 1 w/red, 2 a/yellow, 3 s/blue, 4 enter
- evt_release  out  1  head is a release event (0 = press)
- held  out  NUM_KEYS  bitmap of currently held keys, bit i = code i
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Key map, base set: 15→0, 1D→1, 1C→2, 1B→3, 5A→4. Extended set: only E0 5A (keypad enter) maps to 4. All other bytes and sequences are unmapped and produce no event. Unmapped codes are silently discarded; there is no "none" code.
- Prefix FSM states: IDLE, BRK, EXT, EXT_BRK. Updates only on scan_valid.
  - IDLE: F0→BRK; E0→EXT; other→complete make, stay IDLE.
  - BRK: F0→BRK; E0→EXT (restart); other→complete break, →IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; other→complete extended make, →IDLE.
  - EXT_BRK: F0→EXT_BRK; E0→EXT (restart); other→complete extended break, →IDLE.
- Make of a mapped key:
  - Held bit 0: set the bit and push a press event.
  - Held bit 1 (typematic repeat): no event, bitmap unchanged.
- Break of a mapped key clears its held bit. Breaking an unheld key leaves held unchanged and produces no event.
- FIFO: first-word-fall-through. The head is presented on evt_code/evt_release while evt_valid=1. Pop occurs when evt_valid && evt_ready. Pointers wrap modulo FIFO_DEPTH, with a count of width $clog2(FIFO_DEPTH)+1.
- Push when full:
  - With a pop in the same cycle, the push is accepted and the count is unchanged.
  - Without a pop, the event is dropped and overflow sets. The held bitmap still updates.
- overflow stays 1 until reset.
- Reset (asynchronous, any time, including mid-sequence) forces: FSM IDLE, held 0, FIFO empty, evt_valid 0, evt_code 0, evt_release 0, overflow 0.

## Timing
- Byte completing a sequence sampled at edge N: held updates and the FIFO entry is written at edge N; evt_valid is high after edge N (visible in cycle N+1 if the FIFO was empty).
- Pop at edge M: the next head (or evt_valid=0) is visible after edge M.
- Back-to-back scan_valid every cycle is supported; the throughput is one event per cycle.
- Outputs are registered or FIFO-array driven; there are no combinational paths from scan_* to evt_*.

## Configuration
- KEY_RELEASE_EVT_EN defined:
  - A break that clears a held bit also pushes an event with evt_release=1 and evt_code of that key.
- Undefined:
  - Only press events are queued.
  - evt_release is constant 0 and its FIFO storage bit is not built.

## Test plan
- Reset, then bytes 15, 15, 15 (typematic), F0 15 with evt_ready=1 → exactly one press event code 0. held[0]=1 after the first 15 and 0 after F0 15. With KEY_RELEASE_EVT_EN, a second event follows with code 0, release=1.
- E0 5A, then E0 F0 5A → press code 4 and held[4] 1→0. Bytes E0 15 → no event, held unchanged.
- evt_ready=0 with FIFO_DEPTH=4; press keys 0,1,2,3 then 5A → 4 events queued in order 0,1,2,3. Enter is dropped, overflow=1, held=5'b11111. Draining returns 0,1,2,3 and evt_valid=0.
- FIFO full with a new make arriving in the same cycle as a pop → push accepted, overflow stays 0, count stays 4.
- Unmapped bytes AA, FA, F0 F0 1D, E0 F0 E0 5A → only the final E0 5A yields press code 4. held[1] stays 0.
- Assert rst_n low for one cycle after F0 with the FIFO holding 2 events → all outputs 0 immediately. The next byte 1D yields press code 1 (the pending break is discarded).

Source files
------------

// File: rtl/keycode_event_decoder_if.sv
//==============================================================================
// Module   : keycode_event_decoder_if
// Purpose  : Bundles the scan-byte input strobe and the key-event valid/ready
//            output of keycode_event_decoder. The master modport belongs to
//            the surrounding system and the slave modport to the decoder.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface keycode_event_decoder_if;
   logic       scan_valid;
   logic [7:0] scan_byte;
   logic       evt_valid;
   logic       evt_ready;
   logic [2:0] evt_code;
   logic       evt_release;

   modport master (
      output scan_valid, scan_byte, evt_ready,
      input  evt_valid, evt_code, evt_release
   );

   modport slave (
      input  scan_valid, scan_byte, evt_ready,
      output evt_valid, evt_code, evt_release
   );
endinterface

`default_nettype wire

// File: rtl/keycode_event_decoder.sv
//==============================================================================
// Module   : keycode_event_decoder
// Purpose  : Turns raw PS/2 scan-code bytes into press (and optionally
//            release) events for the Simon game. It tracks the F0/E0 prefixes,
//            suppresses typematic repeats with a held-key bitmap, and queues
//            events in a first-word-fall-through FIFO on a valid/ready port.
// Options  : KEY_RELEASE_EVT_EN - when defined, a break that clears a held key
//            also queues a release event. Otherwise only presses are queued.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module keycode_event_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_KEYS   = 5
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   keycode_event_decoder_if.slave      kb,
   output logic [NUM_KEYS-1:0]         held,
   output logic                        overflow
);

   localparam int              c_AW   = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BRK     = 2'd1,
      S_EXT     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_complete;
   logic                w_is_break;
   logic                w_is_ext;
   logic                w_mapped;
   logic [2:0]          w_code;
   logic [NUM_KEYS-1:0] w_key_mask;
   logic                w_key_held;
   logic                w_make_new;
   logic                w_brk_clr;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_wr;

   logic [NUM_KEYS-1:0] r_held;
   logic                r_overflow;
   logic [c_AW-1:0]     r_wptr;
   logic [c_AW-1:0]     r_rptr;
   logic [c_AW:0]       r_count;
   logic [2:0]          r_mem_code [FIFO_DEPTH];

   // Prefix state register; a reset mid-sequence discards any pending prefix
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Prefix next-state: a non-prefix byte completes a sequence of the current kind
   always_comb begin
      w_state_nxt = r_state;
      w_complete  = 1'b0;
      w_is_break  = 1'b0;
      w_is_ext    = 1'b0;
      if (kb.scan_valid) begin
         if (kb.scan_byte == 8'hF0) begin
            w_state_nxt = (r_state == S_EXT || r_state == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
         end else if (kb.scan_byte == 8'hE0) begin
            w_state_nxt = S_EXT;
         end else begin
            w_state_nxt = S_IDLE;
            w_complete  = 1'b1;
            w_is_break  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
            w_is_ext    = (r_state == S_EXT) || (r_state == S_EXT_BRK);
         end
      end
   end

   // Key map: base set has five keys, extended set only keypad enter
   always_comb begin
      w_mapped = 1'b0;
      w_code   = 3'd0;
      if (!w_is_ext) begin
         case (kb.scan_byte)
            8'h15:   begin w_mapped = 1'b1; w_code = 3'd0; end
            8'h1D:   begin w_mapped = 1'b1; w_code = 3'd1; end
            8'h1C:   begin w_mapped = 1'b1; w_code = 3'd2; end
            8'h1B:   begin w_mapped = 1'b1; w_code = 3'd3; end
            8'h5A:   begin w_mapped = 1'b1; w_code = 3'd4; end
            default: begin w_mapped = 1'b0; w_code = 3'd0; end
         endcase
      end else if (kb.scan_byte == 8'h5A) begin
         w_mapped = 1'b1;
         w_code   = 3'd4;
      end
   end

   // One-hot mask of the decoded key within the held bitmap
   always_comb begin
      w_key_mask = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         w_key_mask[k] = (w_code == 3'(k));
      end
   end

   assign w_key_held = |(r_held & w_key_mask);
   assign w_make_new = w_complete && w_mapped && !w_is_break && !w_key_held;
   assign w_brk_clr  = w_complete && w_mapped &&  w_is_break &&  w_key_held;

`ifdef KEY_RELEASE_EVT_EN
   assign w_push = w_make_new || w_brk_clr;
`else
   assign w_push = w_make_new;
`endif

   assign w_full = (r_count == c_FULL);
   assign w_pop  = kb.evt_valid && kb.evt_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_wr   = w_push && (!w_full || w_pop);

   // Held bitmap and sticky overflow; the bitmap updates even if the event is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_held     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_make_new)                  r_held <= r_held | w_key_mask;
         else if (w_brk_clr)              r_held <= r_held & ~w_key_mask;
         if (w_push && w_full && !w_pop)  r_overflow <= 1'b1;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage for key codes; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (w_wr) r_mem_code[r_wptr] <= w_code;
   end

   assign kb.evt_valid = (r_count != '0);
   assign kb.evt_code  = kb.evt_valid ? r_mem_code[r_rptr] : 3'd0;

`ifdef KEY_RELEASE_EVT_EN
   logic r_mem_rel [FIFO_DEPTH];

   // Release flag storage, written alongside the key code
   always_ff @(posedge clk) begin
      if (w_wr) r_mem_rel[r_wptr] <= w_is_break;
   end

   assign kb.evt_release = kb.evt_valid ? r_mem_rel[r_rptr] : 1'b0;
`else
   assign kb.evt_release = 1'b0;
`endif

   assign held     = r_held;
   assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_keycode_event_decoder.sv
//==============================================================================
// Module   : tb_keycode_event_decoder
// Purpose  : Scoreboard bench for keycode_event_decoder. Stimulus pushes the
//            expected {release, code} of each event into a queue; a monitor
//            on the falling edge pops and compares every accepted event.
//            Honors KEY_RELEASE_EVT_EN to expect release events.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_keycode_event_decoder;

   logic       clk;
   logic       rst_n;
   logic [4:0] held;
   logic       overflow;

   keycode_event_decoder_if kb ();

   keycode_event_decoder #(
      .FIFO_DEPTH (4),
      .NUM_KEYS   (5)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .kb       (kb.slave),
      .held     (held),
      .overflow (overflow)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] exp_q [$];

`ifdef KEY_RELEASE_EVT_EN
   localparam bit c_REL = 1'b1;
`else
   localparam bit c_REL = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic exp_evt(input logic [2:0] code, input logic rel);
      exp_q.push_back({rel, code});
   endtask

   // Byte is sampled at the next rising edge; returns 1 time unit after it
   task automatic send(input logic [7:0] b);
      kb.scan_valid = 1'b1;
      kb.scan_byte  = b;
      @(posedge clk);
      #1;
      kb.scan_valid = 1'b0;
      kb.scan_byte  = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk(name, exp_q.size(), 0);
   endtask

   // Monitor: every accepted head must match the oldest expectation
   always @(negedge clk) begin
      logic [3:0] e;
      if (rst_n && kb.evt_valid && kb.evt_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_evt: got code=%0d rel=%0d, required no event",
                     kb.evt_code, kb.evt_release);
         end else begin
            e = exp_q.pop_front();
            chk("evt", {28'd0, kb.evt_release, kb.evt_code}, {28'd0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      kb.scan_valid = 1'b0;
      kb.scan_byte  = 8'h00;
      kb.evt_ready  = 1'b0;
      #1;
      chk("rst_valid",    kb.evt_valid,   0);
      chk("rst_code",     kb.evt_code,    0);
      chk("rst_release",  kb.evt_release, 0);
      chk("rst_held",     held,           0);
      chk("rst_overflow", overflow,       0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      kb.evt_ready = 1'b1;

      // Typematic repeat suppression and break
      exp_evt(3'd0, 1'b0);
      if (c_REL) exp_evt(3'd0, 1'b1);
      send(8'h15);
      chk("held_after_make", held, 5'b00001);
      send(8'h15);
      send(8'h15);
      chk("held_after_repeat", held, 5'b00001);
      send(8'hF0);
      send(8'h15);
      chk("held_after_break", held, 5'b00000);
      wait_drain("drain_typematic");

      // Extended enter make/break; E0 15 is unmapped
      exp_evt(3'd4, 1'b0);
      if (c_REL) exp_evt(3'd4, 1'b1);
      send(8'hE0);
      send(8'h5A);
      chk("held_ext_make", held, 5'b10000);
      send(8'hE0);
      send(8'hF0);
      send(8'h5A);
      chk("held_ext_break", held, 5'b00000);
      send(8'hE0);
      send(8'h15);
      chk("held_ext_unmapped", held, 5'b00000);
      wait_drain("drain_ext");

      // Overflow: four presses fill the FIFO, enter is dropped
      kb.evt_ready = 1'b0;
      exp_evt(3'd0, 1'b0);
      exp_evt(3'd1, 1'b0);
      exp_evt(3'd2, 1'b0);
      exp_evt(3'd3, 1'b0);
      send(8'h15);
      send(8'h1D);
      send(8'h1C);
      send(8'h1B);
      chk("ovf_before", overflow, 0);
      send(8'h5A);
      chk("ovf_set", overflow, 1);
      chk("ovf_held", held, 5'b11111);
      kb.evt_ready = 1'b1;
      wait_drain("drain_ovf");
      chk("ovf_empty", kb.evt_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // Full FIFO with simultaneous pop and push
      do_reset();
      chk("reset2_ovf", overflow, 0);
      kb.evt_ready = 1'b0;
      exp_evt(3'd0, 1'b0);
      exp_evt(3'd1, 1'b0);
      exp_evt(3'd2, 1'b0);
      exp_evt(3'd3, 1'b0);
      exp_evt(3'd4, 1'b0);
      send(8'h15);
      send(8'h1D);
      send(8'h1C);
      send(8'h1B);
      kb.evt_ready = 1'b1;
      send(8'h5A);
      kb.evt_ready = 1'b0;
      chk("pp_overflow", overflow, 0);
      chk("pp_held", held, 5'b11111);
      chk("pp_valid", kb.evt_valid, 1);
      // Count must still be full: any further push without a pop is dropped
      send(8'hF0);
      send(8'h15);
      send(8'h15);
      chk("pp_full_drop", overflow, 1);
      chk("pp_held2", held, 5'b11111);
      kb.evt_ready = 1'b1;
      wait_drain("drain_pp");
      chk("pp_empty", kb.evt_valid, 0);

      // Unmapped bytes and prefix restarts
      do_reset();
      exp_evt(3'd4, 1'b0);
      send(8'hAA);
      send(8'hFA);
      send(8'hF0);
      send(8'hF0);
      send(8'h1D);
      chk("unm_held1", held, 5'b00000);
      send(8'hE0);
      send(8'hF0);
      send(8'hE0);
      send(8'h5A);
      chk("unm_held", held, 5'b10000);
      wait_drain("drain_unm");

      // Asynchronous reset mid-sequence with two events pending
      do_reset();
      kb.evt_ready = 1'b0;
      send(8'h15);
      send(8'h1D);
      chk("mid_valid", kb.evt_valid, 1);
      send(8'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid",   kb.evt_valid,   0);
      chk("mid_rst_code",    kb.evt_code,    0);
      chk("mid_rst_release", kb.evt_release, 0);
      chk("mid_rst_held",    held,           0);
      chk("mid_rst_ovf",     overflow,       0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      kb.evt_ready = 1'b1;
      exp_evt(3'd1, 1'b0);
      send(8'h1D);
      chk("mid_held", held, 5'b00010);
      wait_drain("drain_mid");
      chk("mid_empty", kb.evt_valid, 0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
